// File: rtl/imem_loader.sv
// Program loader: streams host instruction words into instruction memory while holding
// the core in reset, then releases it with startPC at the load base address.
module imem_loader #(
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic        CLK,
    input  logic        Reset_L,
    input  logic        load_start,
    input  logic [63:0] load_base,
    input  logic [15:0] load_count,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    output logic        imem_we,
    output logic [63:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_reset_L,
    output logic [63:0] startPC,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [1:0] {StIdle, StLoad, StRelease, StRun} state_e;

    state_e      state_q, state_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [15:0] remain_q, remain_d;
    logic        we_q, we_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        rel_q, rel_d;
    logic        count_ok;
    logic        handshake;

    assign count_ok  = (load_count != 16'd0) && (32'(load_count) <= MAX_WORDS);
    assign handshake = (state_q == StLoad) && (remain_q != 16'd0) && in_valid;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        pc_d     = pc_q;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        remain_d = remain_q;
        err_d    = err_q;
        rel_d    = rel_q;
        we_d     = 1'b0;
        done_d   = 1'b0;
        unique case (state_q)
            StIdle, StRun: begin
                if (load_start) begin
                    if (count_ok) begin
                        addr_d   = {load_base[63:2], 2'b00};
                        pc_d     = {load_base[63:2], 2'b00};
                        remain_d = load_count;
                        err_d    = 1'b0;
                        state_d  = StLoad;
                    end else begin
                        // Rejected request leaves everything else, including a running core, alone
                        err_d = 1'b1;
                    end
                end
            end
            StLoad: begin
                if (handshake) begin
                    we_d     = 1'b1;
                    waddr_d  = addr_q;
                    wdata_d  = in_data;
                    addr_d   = addr_q + 64'd4;
                    remain_d = remain_q - 16'd1;
                    if (remain_q == 16'd1) begin
                        state_d = StRelease;
                        rel_d   = 1'b0;
                    end
                end
            end
            StRelease: begin
                // Two-cycle hold so the final write lands before the core leaves reset
                if (rel_q) begin
                    state_d = StRun;
                    done_d  = 1'b1;
                end else begin
                    rel_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state_q  <= StIdle;
            addr_q   <= 64'd0;
            pc_q     <= 64'd0;
            waddr_q  <= 64'd0;
            wdata_q  <= 32'd0;
            remain_q <= 16'd0;
            we_q     <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            rel_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            pc_q     <= pc_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            remain_q <= remain_d;
            we_q     <= we_d;
            done_q   <= done_d;
            err_q    <= err_d;
            rel_q    <= rel_d;
        end
    end

    assign in_ready    = (state_q == StLoad) && (remain_q != 16'd0);
    assign imem_we     = we_q;
    assign imem_addr   = waddr_q;
    assign imem_wdata  = wdata_q;
    assign cpu_reset_L = (state_q == StRun);
    assign startPC     = pc_q;
    assign busy        = (state_q == StLoad) || (state_q == StRelease);
    assign done        = done_q;
    assign error       = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed vector table, reset corner cases and
// randomized traffic against a transaction-level reference model.
module tb_imem_loader;

    localparam int unsigned MAXW = 256;

    logic        CLK = 1'b0;
    logic        Reset_L = 1'b0;
    logic        load_start = 1'b0;
    logic [63:0] load_base = '0;
    logic [15:0] load_count = '0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready, imem_we, cpu_reset_L, busy, done, error;
    logic [63:0] imem_addr, startPC;
    logic [31:0] imem_wdata;

    int n_checks = 0;
    int n_errors = 0;

    imem_loader #(.MAX_WORDS(MAXW)) dut (
        .CLK(CLK), .Reset_L(Reset_L), .load_start(load_start), .load_base(load_base),
        .load_count(load_count), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .cpu_reset_L(cpu_reset_L), .startPC(startPC),
        .busy(busy), .done(done), .error(error)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        ls;
        logic [63:0] base;
        logic [15:0] cnt;
        logic        iv;
        logic [31:0] data;
        logic        rdy;
        logic        we;
        logic [63:0] addr;
        logic [31:0] wdata;
        logic        crst;
        logic        busy;
        logic        done;
        logic        err;
        logic [63:0] pc;
    } vec_t;

    function automatic vec_t mk(logic ls, logic [63:0] base, logic [15:0] cnt, logic iv,
                                logic [31:0] data, logic rdy, logic we, logic [63:0] addr,
                                logic [31:0] wdata, logic crst, logic bsy, logic dn,
                                logic err, logic [63:0] pc);
        vec_t v;
        v.ls = ls; v.base = base; v.cnt = cnt; v.iv = iv; v.data = data;
        v.rdy = rdy; v.we = we; v.addr = addr; v.wdata = wdata; v.crst = crst;
        v.busy = bsy; v.done = dn; v.err = err; v.pc = pc;
        return v;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Address/data only matter when a write is expected, unless full is set
    task automatic check_all(string tag, vec_t e, bit full);
        chk({tag, " in_ready"}, 64'(in_ready), 64'(e.rdy));
        chk({tag, " imem_we"}, 64'(imem_we), 64'(e.we));
        if (e.we || full) begin
            chk({tag, " imem_addr"}, imem_addr, e.addr);
            chk({tag, " imem_wdata"}, 64'(imem_wdata), 64'(e.wdata));
        end
        chk({tag, " cpu_reset_L"}, 64'(cpu_reset_L), 64'(e.crst));
        chk({tag, " busy"}, 64'(busy), 64'(e.busy));
        chk({tag, " done"}, 64'(done), 64'(e.done));
        chk({tag, " error"}, 64'(error), 64'(e.err));
        chk({tag, " startPC"}, startPC, e.pc);
    endtask

    task automatic drive(vec_t v);
        load_start = v.ls;
        load_base  = v.base;
        load_count = v.cnt;
        in_valid   = v.iv;
        in_data    = v.data;
    endtask

    // Reference model: words left, release cycles left, and whether the core runs
    int          m_remain, m_rel;
    bit          m_run, m_err, m_done, m_we;
    logic [63:0] m_addr, m_pc, m_waddr;
    logic [31:0] m_wdata;

    task automatic model_reset();
        m_remain = 0; m_rel = 0; m_run = 0; m_err = 0; m_done = 0; m_we = 0;
        m_addr = '0; m_pc = '0; m_waddr = '0; m_wdata = '0;
    endtask

    task automatic model_step();
        bit quiet;
        bit hs;
        quiet  = (m_remain == 0) && (m_rel == 0);
        hs     = (m_remain > 0) && in_valid;
        m_we   = 0;
        m_done = 0;
        if (hs) begin
            m_we = 1; m_waddr = m_addr; m_wdata = in_data;
            m_addr = m_addr + 64'd4;
            m_remain--;
            if (m_remain == 0) m_rel = 2;
        end else if (m_rel > 0) begin
            m_rel--;
            if (m_rel == 0) begin m_run = 1; m_done = 1; end
        end
        if (quiet && load_start) begin
            if (load_count >= 1 && int'(load_count) <= int'(MAXW)) begin
                m_addr = load_base & ~64'h3;
                m_pc = m_addr; m_remain = int'(load_count); m_err = 0; m_run = 0;
            end else begin
                m_err = 1;
            end
        end
    endtask

    function automatic vec_t model_exp();
        return mk(1'b0, '0, '0, 1'b0, '0, m_remain > 0, m_we, m_waddr, m_wdata, m_run,
                  (m_remain > 0) || (m_rel > 0), m_done, m_err, m_pc);
    endfunction

    task automatic apply_reset();
        Reset_L = 1'b0;
        drive(mk(0, '0, '0, 0, '0, 0, 0, '0, '0, 0, 0, 0, 0, '0));
        @(posedge CLK); #1;
        model_reset();
        check_all("reset", mk(0, '0, '0, 0, '0, 0, 0, '0, '0, 0, 0, 0, 0, '0), 1);
        Reset_L = 1'b1;
    endtask

    localparam logic [31:0] WA = 32'hA000_0001, WB = 32'hB000_0002, WC = 32'hC000_0003;
    localparam logic [31:0] WD = 32'hD000_0004, WE = 32'hE000_0005, WF = 32'hF000_0006;
    localparam logic [31:0] WG = 32'h1234_5678, WH = 32'hCAFE_F00D;
    localparam logic [63:0] TOP = 64'hFFFF_FFFF_FFFF_FFFC;

    vec_t tbl[26];
    vec_t e;

    initial begin
        tbl[0]  = mk(1, 64'h1000, 3, 0, 0,   1, 0, 0, 0, 0, 1, 0, 0, 64'h1000);
        tbl[1]  = mk(0, 0, 0, 1, WA,         1, 1, 64'h1000, WA, 0, 1, 0, 0, 64'h1000);
        tbl[2]  = mk(0, 0, 0, 1, WB,         1, 1, 64'h1004, WB, 0, 1, 0, 0, 64'h1000);
        tbl[3]  = mk(0, 0, 0, 1, WC,         0, 1, 64'h1008, WC, 0, 1, 0, 0, 64'h1000);
        tbl[4]  = mk(0, 0, 0, 0, 0,          0, 0, 0, 0, 0, 1, 0, 0, 64'h1000);
        tbl[5]  = mk(0, 0, 0, 0, 0,          0, 0, 0, 0, 1, 0, 1, 0, 64'h1000);
        tbl[6]  = mk(0, 0, 0, 0, 0,          0, 0, 0, 0, 1, 0, 0, 0, 64'h1000);
        tbl[7]  = mk(1, 64'h2003, 2, 0, 0,   1, 0, 0, 0, 0, 1, 0, 0, 64'h2000);
        tbl[8]  = mk(0, 0, 0, 1, WD,         1, 1, 64'h2000, WD, 0, 1, 0, 0, 64'h2000);
        tbl[9]  = mk(0, 0, 0, 0, 0,          1, 0, 0, 0, 0, 1, 0, 0, 64'h2000);
        tbl[10] = mk(0, 0, 0, 1, WE,         0, 1, 64'h2004, WE, 0, 1, 0, 0, 64'h2000);
        tbl[11] = mk(0, 0, 0, 0, 0,          0, 0, 0, 0, 0, 1, 0, 0, 64'h2000);
        tbl[12] = mk(0, 0, 0, 0, 0,          0, 0, 0, 0, 1, 0, 1, 0, 64'h2000);
        tbl[13] = mk(1, 64'h9000, 0, 0, 0,   0, 0, 0, 0, 1, 0, 0, 1, 64'h2000);
        tbl[14] = mk(1, 64'h9000, 257, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 64'h2000);
        tbl[15] = mk(0, 0, 0, 1, 32'h5,      0, 0, 0, 0, 1, 0, 0, 1, 64'h2000);
        tbl[16] = mk(1, TOP, 2, 0, 0,        1, 0, 0, 0, 0, 1, 0, 0, TOP);
        tbl[17] = mk(0, 0, 0, 1, WF,         1, 1, TOP, WF, 0, 1, 0, 0, TOP);
        tbl[18] = mk(0, 0, 0, 1, WG,         0, 1, 64'h0, WG, 0, 1, 0, 0, TOP);
        tbl[19] = mk(0, 0, 0, 0, 0,          0, 0, 0, 0, 0, 1, 0, 0, TOP);
        tbl[20] = mk(0, 0, 0, 0, 0,          0, 0, 0, 0, 1, 0, 1, 0, TOP);
        tbl[21] = mk(1, 64'h3000, 1, 0, 0,   1, 0, 0, 0, 0, 1, 0, 0, 64'h3000);
        tbl[22] = mk(1, 64'h4000, 2, 1, WH,  0, 1, 64'h3000, WH, 0, 1, 0, 0, 64'h3000);
        tbl[23] = mk(1, 64'h5000, 0, 0, 0,   0, 0, 0, 0, 0, 1, 0, 0, 64'h3000);
        tbl[24] = mk(0, 0, 0, 0, 0,          0, 0, 0, 0, 1, 0, 1, 0, 64'h3000);
        tbl[25] = mk(0, 0, 0, 0, 0,          0, 0, 0, 0, 1, 0, 0, 0, 64'h3000);

        #2;
        apply_reset();
        for (int i = 0; i < 26; i++) begin
            drive(tbl[i]);
            @(posedge CLK); #1;
            check_all($sformatf("vec%0d", i), tbl[i], 0);
        end

        // Rejected requests from IDLE keep the core in reset and write nothing
        apply_reset();
        drive(mk(1, 64'h8000, 0, 1, WA, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge CLK); #1;
        check_all("idle_cnt0", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 0);
        drive(mk(1, 64'h8000, 16'(MAXW + 1), 1, WA, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge CLK); #1;
        check_all("idle_cntmax1", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 0);
        drive(mk(1, 64'h8000, 16'(MAXW), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge CLK); #1;
        check_all("idle_cntmax", mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 64'h8000), 0);

        // Asynchronous reset in the middle of a 4-word load
        apply_reset();
        drive(mk(1, 64'h5000, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge CLK); #1;
        drive(mk(0, 0, 0, 1, WB, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge CLK); #1;
        check_all("mid_word1", mk(0, 0, 0, 0, 0, 1, 1, 64'h5000, WB, 0, 1, 0, 0, 64'h5000), 0);
        #2 Reset_L = 1'b0;
        #1;
        check_all("async_rst", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1);
        for (int i = 0; i < 2; i++) begin
            @(posedge CLK); #1;
            check_all($sformatf("rst_hold%0d", i),
                      mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1);
        end

        // Randomized traffic against the reference model
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            load_start = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 9))
                0:       load_count = 16'd0;
                1:       load_count = 16'(MAXW + $urandom_range(1, 3));
                2:       load_count = 16'(MAXW);
                default: load_count = 16'($urandom_range(1, 12));
            endcase
            load_base = ($urandom_range(0, 5) == 0) ? (TOP - 64'($urandom_range(0, 12)))
                                                    : {$urandom, $urandom};
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            @(posedge CLK);
            model_step();
            #1;
            e = model_exp();
            check_all($sformatf("rnd%0d", c), e, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
